// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: one LIF update engine time-shared over NUM_NEURONS neurons; define LIF_SAT_EN to saturate potentials instead of wrapping
module lif_tdm_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int INPUT_WIDTH = 8,
  parameter int POTENTIAL_WIDTH = 16,
  parameter logic signed [POTENTIAL_WIDTH-1:0] THRESHOLD = 16'sh7000,
  parameter int LEAK_FACTOR = 4,
  parameter int REFRACTORY_PERIOD = 4,
  localparam int IW = $clog2(NUM_NEURONS),
  localparam int SW = $clog2(NUM_NEURONS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          step_start,
  output logic                          step_busy,
  output logic                          step_done,
  output logic [SW-1:0]                 step_spikes,
  input  logic                          cur_valid,
  output logic                          cur_ready,
  input  logic signed [INPUT_WIDTH-1:0] cur_data,
  output logic [IW-1:0]                 cur_idx,
  output logic                          spike_valid,
  output logic [IW-1:0]                 spike_idx,
  input  logic                          spike_ready
);
  localparam int W = POTENTIAL_WIDTH;
  localparam int RW = $clog2(REFRACTORY_PERIOD + 1);
  localparam logic signed [W-1:0] V_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] V_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, UPDATE = 3'd2, EMIT = 3'd3, DONE = 3'd4;
`ifdef LIF_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  logic [2:0] state;
  logic [IW-1:0] idx;
  logic [SW-1:0] tally;
  logic signed [INPUT_WIDTH-1:0] cur_q;
  logic signed [W-1:0] v_mem [NUM_NEURONS];
  logic [RW-1:0] refr_mem [NUM_NEURONS];
  logic signed [W-1:0] v_cur, leak, v_next;
  logic [RW-1:0] r_cur;
  logic signed [W+1:0] sum;
  logic ovf, fire, last;
  logic [2:0] nxt_state;
  logic [IW-1:0] nxt_idx;
  assign step_busy = state != IDLE;
  assign step_done = state == DONE;
  assign cur_ready = state == FETCH;
  assign spike_valid = state == EMIT;
  assign cur_idx = idx;
  assign spike_idx = idx;
  assign last = idx == IW'(NUM_NEURONS - 1);
  assign nxt_state = last ? DONE : FETCH;
  assign nxt_idx = last ? idx : idx + 1'b1;
  // Evaluate the LIF rule for the neuron under service from its pre-update state; the sum keeps two guard bits
  always_comb begin
    v_cur = v_mem[idx];
    r_cur = refr_mem[idx];
    leak = v_cur >>> LEAK_FACTOR;
    sum = {{2{v_cur[W-1]}}, v_cur} + {{(W+2-INPUT_WIDTH){cur_q[INPUT_WIDTH-1]}}, cur_q} - {{2{leak[W-1]}}, leak};
    ovf = !((&sum[W+1:W-1]) || !(|sum[W+1:W-1]));
    v_next = (SAT_EN && ovf) ? (sum[W+1] ? V_MIN : V_MAX) : sum[W-1:0];
    fire = (r_cur == '0) && (v_cur >= THRESHOLD) && (v_cur < V_MAX);
  end
  // Step sequencer: fetch a current, update one neuron, optionally emit its spike, advance to the next
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      tally <= '0;
      cur_q <= '0;
      step_spikes <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_mem[i] <= '0;
        refr_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (step_start) begin
          state <= FETCH;
          idx <= '0;
          tally <= '0;
        end
        FETCH: if (cur_valid) begin
          cur_q <= cur_data;
          state <= UPDATE;
        end
        UPDATE: begin
          v_mem[idx] <= fire ? '0 : (r_cur != '0) ? v_cur : v_next;
          refr_mem[idx] <= fire ? RW'(REFRACTORY_PERIOD) : (r_cur != '0) ? r_cur - 1'b1 : '0;
          tally <= fire ? tally + 1'b1 : tally;
          state <= fire ? EMIT : nxt_state;
          idx <= fire ? idx : nxt_idx;
        end
        EMIT: if (spike_ready) begin
          state <= nxt_state;
          idx <= nxt_idx;
        end
        DONE: begin
          step_spikes <= tally;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
